// File: rtl/router_pkg.sv
// Shared router types: port count, flit formats and output-port FSM states.
package router_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int FLIT_DATA_W  = 32;
    localparam int PORT_IDX_W   = $clog2(NUM_OF_PORTS);

    typedef enum logic [1:0] {
        HEAD_FLIT   = 2'd0,
        BODY_FLIT   = 2'd1,
        TAIL_FLIT   = 2'd2,
        SINGLE_FLIT = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    // src_port names the input the crossbar switched this flit from
    typedef struct packed {
        flit_t                 flit;
        logic [PORT_IDX_W-1:0] src_port;
    } router_pipeline_bus_t;

    typedef enum logic {
        OP_IDLE   = 1'b0,
        OP_ACTIVE = 1'b1
    } OUTPORT_STATE;

    function automatic logic is_last(flit_type_t t);
        return (t == TAIL_FLIT) || (t == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/switch_outport_alloc_if.sv
// Output-port bundle: crossbar request/ack, switched flit, link flit and credit status.
// OUTPORT_TIMEOUT_EN adds the o_timeout pulse.
interface switch_outport_alloc_if
    import router_pkg::*;
#(
    parameter int BUF_DEPTH = 4
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_OF_PORTS-1:0] i_outport_req;
    logic [NUM_OF_PORTS-1:0] o_outport_ack;
    router_pipeline_bus_t    i_s2o;
    logic                    i_flit_valid;
    logic                    o_ready;
    flit_t                   o_flit;
    logic                    o_flit_valid;
    logic                    i_credit;
    logic [CNT_W-1:0]        o_credit_cnt;
    logic                    o_busy;
    logic                    o_credit_err;
`ifdef OUTPORT_TIMEOUT_EN
    logic                    o_timeout;
`endif

    modport master (
`ifdef OUTPORT_TIMEOUT_EN
        input  o_timeout,
`endif
        output i_outport_req, i_s2o, i_flit_valid, i_credit,
        input  o_outport_ack, o_ready, o_flit, o_flit_valid,
        input  o_credit_cnt, o_busy, o_credit_err
    );

    modport slave (
`ifdef OUTPORT_TIMEOUT_EN
        output o_timeout,
`endif
        input  i_outport_req, i_s2o, i_flit_valid, i_credit,
        output o_outport_ack, o_ready, o_flit, o_flit_valid,
        output o_credit_cnt, o_busy, o_credit_err
    );

endinterface

// File: rtl/switch_outport_alloc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N     = 5,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int idx;

    // Walk from farthest to nearest so the nearest requester is written last
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_outport_alloc.sv
// Per-output allocator: round-robin lock from head to tail, registered link stage, credit flow control.
// OUTPORT_TIMEOUT_EN enables the idle-lock watchdog and its o_timeout pulse.
//
// state     | meaning
// OP_IDLE   | no lock; arbitrating requests, o_ready low
// OP_ACTIVE | locked to one input; flits pass while credits remain
module switch_outport_alloc
    import router_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int BUF_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_outport_alloc_if.slave bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = PORT_IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

    OUTPORT_STATE            state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        ptr_next;
    logic [NUM_OF_PORTS-1:0] gnt;
    logic [CNT_W-1:0]        credit_cnt;
    logic                    accept;

`ifdef OUTPORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    rr_arbiter #(.N(NUM_OF_PORTS)) u_rr_arbiter (
        .req   (bus.i_outport_req),
        .ptr   (rr_ptr),
        .grant (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
        ptr_next = (gnt_idx == PTR_W'(NUM_OF_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    assign bus.o_ready      = (state == OP_ACTIVE) && (credit_cnt != '0);
    assign accept           = bus.i_flit_valid && bus.o_ready;
    assign bus.o_busy       = (state == OP_ACTIVE);
    assign bus.o_credit_cnt = credit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= OP_IDLE;
            rr_ptr            <= '0;
            credit_cnt        <= CNT_MAX;
            bus.o_outport_ack <= '0;
            bus.o_flit        <= '0;
            bus.o_flit_valid  <= 1'b0;
            bus.o_credit_err  <= 1'b0;
`ifdef OUTPORT_TIMEOUT_EN
            to_cnt            <= '0;
            bus.o_timeout     <= 1'b0;
`endif
        end else begin
            bus.o_flit_valid <= accept;
            if (accept) bus.o_flit <= bus.i_s2o.flit;

            // Simultaneous accept and credit return cancel out
            if (accept && !bus.i_credit) begin
                credit_cnt <= credit_cnt - CNT_W'(1);
            end else if (!accept && bus.i_credit) begin
                if (credit_cnt == CNT_MAX) bus.o_credit_err <= 1'b1;
                else                       credit_cnt <= credit_cnt + CNT_W'(1);
            end

`ifdef OUTPORT_TIMEOUT_EN
            bus.o_timeout <= 1'b0;
`endif
            case (state)
                OP_IDLE: begin
`ifdef OUTPORT_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    if (|bus.i_outport_req) begin
                        bus.o_outport_ack <= gnt;
                        rr_ptr            <= ptr_next;
                        state             <= OP_ACTIVE;
                    end
                end
                OP_ACTIVE: begin
                    if (accept && is_last(bus.i_s2o.flit.flit_type)) begin
                        bus.o_outport_ack <= '0;
                        state             <= OP_IDLE;
                    end
`ifdef OUTPORT_TIMEOUT_EN
                    else if (!accept && to_cnt == TO_LAST) begin
                        bus.o_outport_ack <= '0;
                        bus.o_timeout     <= 1'b1;
                        to_cnt            <= '0;
                        state             <= OP_IDLE;
                    end else if (accept) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= OP_IDLE;
            endcase
        end
    end

    a_params: assert property (@(posedge clk)
        (PORT_ID < NUM_OF_PORTS) && (BUF_DEPTH >= 1) && (TIMEOUT >= 1));

    a_no_flit_when_idle: assert property (@(posedge clk) disable iff (rst)
        !(state == OP_IDLE && bus.i_flit_valid));

    a_flit_from_granted: assert property (@(posedge clk) disable iff (rst)
        accept |-> bus.o_outport_ack[bus.i_s2o.src_port]);

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.o_outport_ack));

endmodule

// File: tb/tb_switch_outport_alloc.sv
// Directed bench for switch_outport_alloc: link flits checked by scoreboard, control/credit state checked inline.
module tb_switch_outport_alloc;
    import router_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    switch_outport_alloc_if #(.BUF_DEPTH(4)) bus4 ();
    switch_outport_alloc_if #(.BUF_DEPTH(2)) bus2 ();

    switch_outport_alloc #(.PORT_ID(0), .BUF_DEPTH(4), .TIMEOUT(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    switch_outport_alloc #(.PORT_ID(1), .BUF_DEPTH(2), .TIMEOUT(8)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    flit_t exp4[$];
    flit_t exp2[$];
    flit_t e4, e2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(flit_type_t t, logic [31:0] d);
        flit_t f;
        f.flit_type = t;
        f.data      = d;
        return f;
    endfunction

    task automatic drv4(input flit_type_t t, input logic [31:0] d, input logic [2:0] src);
        bus4.i_s2o.flit     = mk(t, d);
        bus4.i_s2o.src_port = src;
        bus4.i_flit_valid   = 1'b1;
        exp4.push_back(mk(t, d));
    endtask

    task automatic drv2(input flit_type_t t, input logic [31:0] d, input logic [2:0] src);
        bus2.i_s2o.flit     = mk(t, d);
        bus2.i_s2o.src_port = src;
        bus2.i_flit_valid   = 1'b1;
        exp2.push_back(mk(t, d));
    endtask

    // Scoreboard monitors: every link flit must match the next flit issued to that port
    always @(negedge clk) begin
        if (!rst && bus4.o_flit_valid === 1'b1) begin
            if (exp4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb4_unexpected: got flit 0x%0h expected none", bus4.o_flit);
            end else begin
                e4 = exp4.pop_front();
                chk("sb4_flit", 64'(bus4.o_flit), 64'(e4));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus2.o_flit_valid === 1'b1) begin
            if (exp2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb2_unexpected: got flit 0x%0h expected none", bus2.o_flit);
            end else begin
                e2 = exp2.pop_front();
                chk("sb2_flit", 64'(bus2.o_flit), 64'(e2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int gidx[6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] exp_ack;

    initial begin
        bus4.i_outport_req = '0;
        bus4.i_s2o         = '0;
        bus4.i_flit_valid  = 1'b0;
        bus4.i_credit      = 1'b0;
        bus2.i_outport_req = '0;
        bus2.i_s2o         = '0;
        bus2.i_flit_valid  = 1'b0;
        bus2.i_credit      = 1'b0;
        rst = 1'b1;
        step();
        step();

        chk("rst_ack",   64'(bus4.o_outport_ack), 64'(0));
        chk("rst_ready", 64'(bus4.o_ready),       64'(0));
        chk("rst_fval",  64'(bus4.o_flit_valid),  64'(0));
        chk("rst_flit",  64'(bus4.o_flit),        64'(0));
        chk("rst_cnt",   64'(bus4.o_credit_cnt),  64'(4));
        chk("rst_busy",  64'(bus4.o_busy),        64'(0));
        chk("rst_err",   64'(bus4.o_credit_err),  64'(0));
        rst = 1'b0;
        step();
        chk("idle_ack", 64'(bus4.o_outport_ack), 64'(0));

        // Round-robin over all requesters with single-flit packets
        bus4.i_outport_req = 5'b11111;
        for (int p = 0; p < 6; p++) begin
            step();
            exp_ack = 5'b00001 << gidx[p];
            chk("rr_ack",   64'(bus4.o_outport_ack), 64'(exp_ack));
            chk("rr_busy",  64'(bus4.o_busy),        64'(1));
            drv4(SINGLE_FLIT, 32'hA000_0000 + 32'(p), 3'(gidx[p]));
            bus4.i_credit = (p != 0);
            step();
            bus4.i_flit_valid = 1'b0;
            bus4.i_credit     = 1'b0;
            chk("rr_ack_drop", 64'(bus4.o_outport_ack), 64'(0));
            chk("rr_fval",     64'(bus4.o_flit_valid),  64'(1));
            chk("rr_cnt",      64'(bus4.o_credit_cnt),  64'(3));
        end
        bus4.i_outport_req = '0;

        // Credit return up to full, then one extra
        bus4.i_credit = 1'b1;
        step();
        chk("cr_cnt_full", 64'(bus4.o_credit_cnt), 64'(4));
        chk("cr_err_low",  64'(bus4.o_credit_err), 64'(0));
        step();
        bus4.i_credit = 1'b0;
        chk("cr_cnt_sat",  64'(bus4.o_credit_cnt), 64'(4));
        chk("cr_err_set",  64'(bus4.o_credit_err), 64'(1));

        // Head/body/tail packet from input 2
        bus4.i_outport_req = 5'b00100;
        step();
        bus4.i_outport_req = '0;
        chk("pkt_ack",   64'(bus4.o_outport_ack), 64'(5'b00100));
        chk("pkt_ready", 64'(bus4.o_ready),       64'(1));
        drv4(HEAD_FLIT, 32'h1111_0001, 3'd2);
        step();
        chk("pkt_cnt3", 64'(bus4.o_credit_cnt),  64'(3));
        chk("pkt_fv1",  64'(bus4.o_flit_valid),  64'(1));
        chk("pkt_hold", 64'(bus4.o_outport_ack), 64'(5'b00100));
        drv4(BODY_FLIT, 32'h2222_0002, 3'd2);
        step();
        chk("pkt_cnt2", 64'(bus4.o_credit_cnt),  64'(2));
        chk("pkt_fv2",  64'(bus4.o_flit_valid),  64'(1));
        drv4(TAIL_FLIT, 32'h3333_0003, 3'd2);
        step();
        bus4.i_flit_valid = 1'b0;
        chk("pkt_cnt1",  64'(bus4.o_credit_cnt),  64'(1));
        chk("pkt_fv3",   64'(bus4.o_flit_valid),  64'(1));
        chk("pkt_ackz",  64'(bus4.o_outport_ack), 64'(0));
        chk("pkt_busyz", 64'(bus4.o_busy),        64'(0));
        step();
        chk("pkt_fv_end", 64'(bus4.o_flit_valid), 64'(0));

        // Reset while locked with one credit left
        bus4.i_outport_req = 5'b00100;
        step();
        bus4.i_outport_req = '0;
        chk("arst_pre_ack", 64'(bus4.o_outport_ack), 64'(5'b00100));
        chk("arst_pre_cnt", 64'(bus4.o_credit_cnt),  64'(1));
        rst = 1'b1;
        #1;
        chk("arst_ack",  64'(bus4.o_outport_ack), 64'(0));
        chk("arst_busy", 64'(bus4.o_busy),        64'(0));
        chk("arst_cnt",  64'(bus4.o_credit_cnt),  64'(4));
        chk("arst_err",  64'(bus4.o_credit_err),  64'(0));
        step();
        rst = 1'b0;
        step();

        // Credit starvation with BUF_DEPTH=2
        bus2.i_outport_req = 5'b00010;
        step();
        bus2.i_outport_req = '0;
        chk("b2_ack", 64'(bus2.o_outport_ack), 64'(5'b00010));
        drv2(HEAD_FLIT, 32'hB000_0001, 3'd1);
        step();
        chk("b2_cnt1",   64'(bus2.o_credit_cnt), 64'(1));
        chk("b2_ready1", 64'(bus2.o_ready),      64'(1));
        drv2(BODY_FLIT, 32'hB000_0002, 3'd1);
        step();
        chk("b2_cnt0",   64'(bus2.o_credit_cnt), 64'(0));
        chk("b2_ready0", 64'(bus2.o_ready),      64'(0));
        drv2(TAIL_FLIT, 32'hB000_0003, 3'd1);
        step();
        chk("b2_stall_fv",  64'(bus2.o_flit_valid),  64'(0));
        chk("b2_stall_cnt", 64'(bus2.o_credit_cnt),  64'(0));
        bus2.i_credit = 1'b1;
        step();
        bus2.i_credit = 1'b0;
        chk("b2_cr_cnt",   64'(bus2.o_credit_cnt), 64'(1));
        chk("b2_cr_ready", 64'(bus2.o_ready),      64'(1));
        step();
        bus2.i_flit_valid = 1'b0;
        chk("b2_tail_fv",  64'(bus2.o_flit_valid),  64'(1));
        chk("b2_tail_cnt", 64'(bus2.o_credit_cnt),  64'(0));
        chk("b2_tail_ack", 64'(bus2.o_outport_ack), 64'(0));

`ifdef OUTPORT_TIMEOUT_EN
        // Idle-lock watchdog: grant with no flits times out after TIMEOUT cycles
        bus4.i_outport_req = 5'b00001;
        step();
        bus4.i_outport_req = '0;
        chk("to_grant", 64'(bus4.o_outport_ack), 64'(5'b00001));
        for (int k = 1; k < 8; k++) begin
            step();
            chk("to_hold_ack", 64'(bus4.o_outport_ack), 64'(5'b00001));
            chk("to_hold_pls", 64'(bus4.o_timeout),     64'(0));
        end
        step();
        chk("to_ack",  64'(bus4.o_outport_ack), 64'(0));
        chk("to_pls",  64'(bus4.o_timeout),     64'(1));
        chk("to_busy", 64'(bus4.o_busy),        64'(0));
        step();
        chk("to_pls_end", 64'(bus4.o_timeout), 64'(0));
`endif

        step();
        @(negedge clk);
        #1;
        chk("sb4_drain", 64'(exp4.size()), 64'(0));
        chk("sb2_drain", 64'(exp2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_outport_alloc.md
# switch_outport_alloc

Per-output-port allocator and link driver: the responder side of the crossbar's output-port request/ack handshake. One instance per router output. It takes the request column addressed to its port from all input ports and grants one input with a round-robin one-hot ack. It holds that grant from head flit to tail flit, forwards the switched flits onto the outgoing link through one register stage, and enforces downstream credit-based flow control.

## Interface
- PORT_ID, 0: index of this output port (0..NUM_OF_PORTS-1); used only in assertions.
- BUF_DEPTH, 4: downstream input-buffer depth, which is the initial and maximum credit count; must be ≥1.
- TIMEOUT, 64: idle-lock watchdog limit in cycles; only meaningful with OUTPORT_TIMEOUT_EN.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_outport_req  in  NUM_OF_PORTS  bit k = input port k requests this output.
- o_outport_ack  out  NUM_OF_PORTS  one-hot grant to the locked input; all-zero when idle.
- i_s2o  in  router_pipeline_bus_t  flit from the crossbar for this output.
- i_flit_valid  in  1  i_s2o carries a valid flit.
- o_ready  out  1  flit is accepted this cycle if i_flit_valid=1.
- o_flit  out  flit_t  registered link flit.
- o_flit_valid  out  1  o_flit valid, pulsed once per flit.
- i_credit  in  1  one-cycle credit return from downstream.
- o_credit_cnt  out  $clog2(BUF_DEPTH+1)  current credits.
- o_busy  out  1  port locked to an input.
- o_credit_err  out  1  sticky; a credit arrived while the count was already BUF_DEPTH.

## Operation
- FSM states: IDLE, ACTIVE.
- IDLE, with any request bit set:
  - Pick the first set bit at or after rr_ptr, wrapping modulo NUM_OF_PORTS.
  - Register the pick as a one-hot ack and go to ACTIVE.
  - Set rr_ptr = granted index + 1, wrapping 4→0.
  - No request: stay in IDLE with ack = 0.
- ACTIVE:
  - The ack is held constant; request changes are ignored.
  - o_ready = (credit_cnt ≠ 0).
  - Accept = i_flit_valid & o_ready. On accept, register the flit and decrement credits.
  - An accepted flit with flit_type TAIL_FLIT or SINGLE_FLIT moves the FSM to IDLE and clears the ack.
- IDLE: o_ready = 0. A valid flit arriving in IDLE is not accepted and asserts an assertion failure in simulation.
- Credit arithmetic:
  - Accept only: −1. i_credit only: +1. Both in the same cycle: unchanged.
  - i_credit while the count is BUF_DEPTH: the count stays at BUF_DEPTH and o_credit_err is set.
  - The count never underflows, because accept requires a nonzero count.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, o_outport_ack 0, o_ready 0.
  - o_flit 0, o_flit_valid 0.
  - o_credit_cnt BUF_DEPTH, o_busy 0, o_credit_err 0.
- Request sampled at cycle N produces the ack at N+1.
- A flit accepted at cycle M appears on o_flit with o_flit_valid=1 at M+1, and o_credit_cnt reflects it at M+1.
- A tail accepted at M: the ack drops at M+1. The next grant is sampled at M+1 and visible at M+2.
- Credit returned at M is usable (o_ready can rise) at M+1.
- Reset asserted mid-packet aborts immediately: the lock is dropped and credits are restored to BUF_DEPTH. No partial-packet recovery is attempted.

## Configuration
- Macro: OUTPORT_TIMEOUT_EN.
- Defined:
  - A counter runs in ACTIVE and clears on every accept.
  - When it reaches TIMEOUT, the FSM forces IDLE, clears the ack, and pulses the extra output o_timeout for one cycle.
  - The counter is cleared on entry to IDLE.
- Undefined: no counter and no o_timeout port. The lock is held until a tail is accepted.

## Structure
- The following belong in router_pkg:
  - NUM_OF_PORTS
  - flit_t and router_pipeline_bus_t
  - the flit_type enum, which gains SINGLE_FLIT
  - the OUTPORT_STATE enum {OP_IDLE, OP_ACTIVE}
- Sub-module rr_arbiter: parameterised N, with req, ptr, and one-hot grant. It is combinational pick logic; the pointer register stays in the parent.
- The credit counter and FSM stay in the parent.

## Test plan
- Reset, then req=5'b00100 → ack=00100 at next cycle; head/body/tail accepted → three o_flit_valid pulses each one cycle later; credits go 4→1; ack=0 after tail.
- req=5'b11111 held across four single-flit packets → grants in order 00001, 00010, 00100, 01000; rr_ptr=4.
- BUF_DEPTH=2, no credits returned, 3-flit packet → o_ready=0 after the second accept; i_credit pulse → third flit accepted the next cycle.
- i_credit and accept in the same cycle at count 3 → count stays 3. i_credit at count 4 → count stays 4 and o_credit_err=1.
- rst asserted while ACTIVE with count 1 → in the same cycle ack=0, o_busy=0, count=4.
- With OUTPORT_TIMEOUT_EN and TIMEOUT=8: grant, then no flits → o_timeout pulse and ack=0 exactly 8 cycles after the last accept or the grant.
